// File: rtl/pipe_trace_buffer.sv
`default_nettype none
//============================================================================
// Module      : pipe_trace_buffer
// Description : On-chip event tracer for the pipelined CPU. Per-channel
//               events are recorded into a circular buffer as
//               {cycle stamp, channel id, payload}. Capture starts on a
//               trigger while ARMED and runs for WINDOW cycles (0 =
//               unlimited), until stop, or until the buffer fills (stop
//               mode). In wrap mode, new records overwrite the oldest ones.
//               In DONE, records drain oldest-first over a valid/ready port.
// Ports       : clk_i/rst_i        clock, async active-high reset
//               arm_i/trig_i/stop_i capture control (arm > stop > trig)
//               mode_wrap_i         0 = stop when full, 1 = overwrite oldest
//               ev_valid_i/ev_data_i per-channel event strobes/payloads
//               rd_ready_i/rd_valid_o/rd_data_o  readout handshake
//               state_o/count_o/drop_o/cycle_o   status
// Revision    : 1.0 - initial release
//============================================================================
module pipe_trace_buffer #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 64,
    parameter int STAMP_W = 16,
    parameter int WINDOW  = 18,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW     = $clog2(DEPTH),
    localparam int REC_W  = STAMP_W + CH_W + DATA_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     arm_i,
    input  logic                     trig_i,
    input  logic                     stop_i,
    input  logic                     mode_wrap_i,
    input  logic [NUM_CH-1:0]        ev_valid_i,
    input  logic [NUM_CH*DATA_W-1:0] ev_data_i,
    input  logic                     rd_ready_i,
    output logic                     rd_valid_o,
    output logic [REC_W-1:0]         rd_data_o,
    output logic [1:0]               state_o,
    output logic [AW:0]              count_o,
    output logic [15:0]              drop_o,
    output logic [STAMP_W-1:0]       cycle_o
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ARMED   = 2'd1;
    localparam logic [1:0] c_ST_CAPTURE = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

    localparam logic [AW:0]        c_DEPTH    = (AW + 1)'(DEPTH);
    localparam logic [STAMP_W-1:0] c_WIN_LAST = STAMP_W'((WINDOW > 0) ? WINDOW - 1 : 0);
    localparam bit                 c_WIN_EN   = (WINDOW > 0);
    localparam bit                 c_WIN_ONE  = (WINDOW == 1);

    // Registered state
    logic [1:0]         r_state;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic [15:0]        r_drop;
    logic [STAMP_W-1:0] r_cycle;
    logic               r_wrap;
    logic [REC_W-1:0]   r_rd_data;
    logic [REC_W-1:0]   r_mem [DEPTH];

    // Combinational
    logic [1:0]         w_state_nxt;
    logic               w_any;
    logic [CH_W-1:0]    w_win;
    logic [DATA_W-1:0]  w_pay;
    logic [CH_W:0]      w_nev;
    logic [CH_W:0]      w_drop_inc;
    logic [16:0]        w_drop_sum;
    logic [15:0]        w_drop_nxt;
    logic               w_full;
    logic               w_capt;
    logic               w_wr_en;
    logic               w_ovr;
    logic               w_fill;
    logic               w_pop;
    logic [STAMP_W-1:0] w_stamp;
    logic [REC_W-1:0]   w_rec;
    logic [AW-1:0]      w_rd_ptr_nxt;

    // Priority pick: scanning from the top down leaves the lowest asserted
    // channel as the winner; the same pass counts asserted channels.
    always_comb begin : p_pick
        w_any = 1'b0;
        w_win = '0;
        w_pay = '0;
        w_nev = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ev_valid_i[k]) begin
                w_any = 1'b1;
                w_win = CH_W'(k);
                w_pay = ev_data_i[k*DATA_W +: DATA_W];
                w_nev = w_nev + 1'b1;
            end
        end
    end

    always_comb begin : p_ctrl
        w_full  = (r_count == c_DEPTH);
        // Capture cycle: trigger cycle in ARMED or any CAPTURE cycle, unless
        // a higher-priority arm/stop claims it.
        w_capt  = !arm_i && !stop_i &&
                  (((r_state == c_ST_ARMED) && trig_i) || (r_state == c_ST_CAPTURE));
        w_wr_en = w_capt && w_any && (!w_full || r_wrap);
        w_ovr   = w_wr_en && w_full;
        w_fill  = w_wr_en && !r_wrap && (r_count == c_DEPTH - 1'b1);
        w_pop   = !arm_i && (r_state == c_ST_DONE) && (r_count != '0) && rd_ready_i;
        w_stamp = (r_state == c_ST_ARMED) ? '0 : r_cycle;
        w_rec   = {w_stamp, w_win, w_pay};

        w_drop_inc = '0;
        if (w_capt && w_any) begin
            w_drop_inc = w_wr_en ? (w_nev - 1'b1) : w_nev;
        end
        w_drop_sum = {1'b0, r_drop} + 17'(w_drop_inc);
        w_drop_nxt = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

        // Overwrite in wrap mode discards the oldest entry, so the head
        // moves exactly like a pop.
        w_rd_ptr_nxt = r_rd_ptr;
        if (arm_i) begin
            w_rd_ptr_nxt = '0;
        end else if (w_ovr || w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + 1'b1;
        end
    end

    always_comb begin : p_next_state
        w_state_nxt = r_state;
        if (arm_i) begin
            w_state_nxt = c_ST_ARMED;
        end else begin
            case (r_state)
                c_ST_ARMED: begin
                    if (stop_i) begin
                        w_state_nxt = c_ST_DONE;
                    end else if (trig_i) begin
                        w_state_nxt = (c_WIN_ONE || w_fill) ? c_ST_DONE : c_ST_CAPTURE;
                    end
                end
                c_ST_CAPTURE: begin
                    if (stop_i || w_fill || (c_WIN_EN && (r_cycle == c_WIN_LAST))) begin
                        w_state_nxt = c_ST_DONE;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin : p_regs
        if (rst_i) begin
            r_state   <= c_ST_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_drop    <= '0;
            r_cycle   <= '0;
            r_wrap    <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            if (arm_i) begin
                r_wr_ptr <= '0;
                r_count  <= '0;
                r_drop   <= '0;
                r_cycle  <= '0;
                r_wrap   <= mode_wrap_i;
            end else begin
                if (w_wr_en) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_wr_en && !w_full) begin
                    r_count <= r_count + 1'b1;
                end else if (w_pop) begin
                    r_count <= r_count - 1'b1;
                end
                r_drop <= w_drop_nxt;
                // The trigger cycle is capture cycle 0, so the first CAPTURE
                // cycle shows 1.
                if ((r_state == c_ST_ARMED) && trig_i && !stop_i) begin
                    r_cycle <= STAMP_W'(1);
                end else if ((r_state == c_ST_CAPTURE) && (r_cycle != '1)) begin
                    r_cycle <= r_cycle + 1'b1;
                end
            end
            // Head register: bypass a record landing in the head slot this
            // cycle so a freshly written head is not read stale.
            if (w_wr_en && (r_wr_ptr == w_rd_ptr_nxt)) begin
                r_rd_data <= w_rec;
            end else begin
                r_rd_data <= r_mem[w_rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk_i) begin : p_mem
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    assign rd_valid_o = (r_state == c_ST_DONE) && (r_count != '0);
    assign rd_data_o  = r_rd_data;
    assign state_o    = r_state;
    assign count_o    = r_count;
    assign drop_o     = r_drop;
    assign cycle_o    = r_cycle;

endmodule
`default_nettype wire

// File: tb/tb_pipe_trace_buffer.sv
`default_nettype none
//============================================================================
// Module      : tb_pipe_trace_buffer
// Description : Directed self-checking bench for pipe_trace_buffer. Two
//               instances share all inputs: one with the default 18-cycle
//               window, one with an unlimited window (WINDOW=0).
// Revision    : 1.0 - initial release
//============================================================================
module tb_pipe_trace_buffer;

    localparam int REC_W = 50;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         arm = 1'b0;
    logic         trig = 1'b0;
    logic         stop = 1'b0;
    logic         wrap = 1'b0;
    logic         rd_ready = 1'b0;
    logic [3:0]   ev_valid = '0;
    logic [127:0] ev_data = '0;

    logic             a_rd_valid, b_rd_valid;
    logic [REC_W-1:0] a_rd_data, b_rd_data;
    logic [1:0]       a_state, b_state;
    logic [6:0]       a_count, b_count;
    logic [15:0]      a_drop, b_drop;
    logic [15:0]      a_cycle, b_cycle;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_trace_buffer u_win (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .trig_i(trig), .stop_i(stop),
        .mode_wrap_i(wrap), .ev_valid_i(ev_valid), .ev_data_i(ev_data),
        .rd_ready_i(rd_ready), .rd_valid_o(a_rd_valid), .rd_data_o(a_rd_data),
        .state_o(a_state), .count_o(a_count), .drop_o(a_drop), .cycle_o(a_cycle)
    );

    pipe_trace_buffer #(.WINDOW(0)) u_unl (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .trig_i(trig), .stop_i(stop),
        .mode_wrap_i(wrap), .ev_valid_i(ev_valid), .ev_data_i(ev_data),
        .rd_ready_i(rd_ready), .rd_valid_o(b_rd_valid), .rd_data_o(b_rd_data),
        .state_o(b_state), .count_o(b_count), .drop_o(b_drop), .cycle_o(b_cycle)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rec(input int st, input int ch, input logic [31:0] d);
        logic [49:0] r;
        r = {16'(st), 2'(ch), d};
        return 64'(r);
    endfunction

    initial begin
        // ---------------- reset state ----------------
        tick(); tick();
        rst = 1'b0;
        chk("rst_state", 64'(a_state), 64'd0);
        chk("rst_count", 64'(a_count), 64'd0);
        chk("rst_drop", 64'(a_drop), 64'd0);
        chk("rst_cycle", 64'(a_cycle), 64'd0);
        chk("rst_valid", 64'(a_rd_valid), 64'd0);
        chk("rst_data", 64'(a_rd_data), 64'd0);
        tick();
        // events in IDLE are ignored
        ev_valid = 4'b0001; tick(); ev_valid = '0;
        chk("idle_count", 64'(a_count), 64'd0);

        // ---------------- basic window ----------------
        arm = 1'b1; tick(); arm = 1'b0;
        chk("arm_state", 64'(a_state), 64'd1);
        trig = 1'b1; ev_valid = 4'b0010; ev_data[63:32] = 32'h11;
        tick();                                   // capture cycle 0
        trig = 1'b0; ev_valid = '0;
        chk("win_state_cap", 64'(a_state), 64'd2);
        chk("win_count1", 64'(a_count), 64'd1);
        chk("win_cycle1", 64'(a_cycle), 64'd1);
        tick(); tick();                           // cycles 1,2
        ev_valid = 4'b0001; ev_data[31:0] = 32'hAA;
        tick();                                   // cycle 3
        ev_valid = '0;
        for (int i = 4; i < 17; i++) tick();      // cycles 4..16
        chk("win_state_c17", 64'(a_state), 64'd2);
        chk("win_cycle17", 64'(a_cycle), 64'd17);
        tick();                                   // cycle 17, last
        chk("win_state_done", 64'(a_state), 64'd3);
        chk("win_count2", 64'(a_count), 64'd2);
        chk("win_valid", 64'(a_rd_valid), 64'd1);
        chk("win_rec0", 64'(a_rd_data), rec(0, 1, 32'h11));
        rd_ready = 1'b1; tick();
        chk("win_rec1", 64'(a_rd_data), rec(3, 0, 32'hAA));
        chk("win_count_pop", 64'(a_count), 64'd1);
        tick();
        rd_ready = 1'b0;
        chk("win_empty_valid", 64'(a_rd_valid), 64'd0);
        chk("win_empty_state", 64'(a_state), 64'd3);

        // ---------------- collision ----------------
        arm = 1'b1; tick(); arm = 1'b0;
        trig = 1'b1; ev_valid = 4'b1101;
        ev_data = {32'h3, 32'h2, 32'h0, 32'h1};
        tick();
        trig = 1'b0;
        chk("col_drop", 64'(a_drop), 64'd2);
        chk("col_count", 64'(a_count), 64'd1);
        stop = 1'b1; ev_valid = 4'b0011;          // stop cycle records nothing
        tick();
        stop = 1'b0; ev_valid = '0;
        chk("col_stop_state", 64'(a_state), 64'd3);
        chk("col_stop_count", 64'(a_count), 64'd1);
        chk("col_stop_drop", 64'(a_drop), 64'd2);
        chk("col_rec", 64'(a_rd_data), rec(1 - 1, 0, 32'h1));

        // ---------------- stop-full (unlimited window) ----------------
        wrap = 1'b0; arm = 1'b1; tick(); arm = 1'b0;
        chk("full_arm_count", 64'(b_count), 64'd0);
        for (int i = 0; i < 64; i++) begin
            trig = (i == 0);
            ev_valid = 4'b0001;
            ev_data[31:0] = 32'h100 + i;
            if (i == 63) begin
                chk("full_pre_state", 64'(b_state), 64'd2);
                chk("full_pre_count", 64'(b_count), 64'd63);
            end
            tick();
        end
        trig = 1'b0;
        chk("full_state", 64'(b_state), 64'd3);
        chk("full_count", 64'(b_count), 64'd64);
        tick(); tick();                           // events after DONE ignored
        ev_valid = '0;
        chk("full_count_hold", 64'(b_count), 64'd64);
        chk("full_drop", 64'(b_drop), 64'd0);
        chk("full_first", 64'(b_rd_data), rec(0, 0, 32'h100));
        rd_ready = 1'b1;
        for (int i = 0; i < 63; i++) tick();
        rd_ready = 1'b0;
        chk("full_last_count", 64'(b_count), 64'd1);
        chk("full_last", 64'(b_rd_data), rec(63, 0, 32'h13F));

        // ---------------- wrap ----------------
        wrap = 1'b1; arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i < 70; i++) begin
            trig = (i == 0);
            ev_valid = 4'b0001;
            ev_data[31:0] = 32'h200 + i;
            tick();
        end
        trig = 1'b0; ev_valid = '0;
        stop = 1'b1; tick(); stop = 1'b0;
        chk("wrap_state", 64'(b_state), 64'd3);
        chk("wrap_count", 64'(b_count), 64'd64);
        chk("wrap_drop", 64'(b_drop), 64'd0);
        chk("wrap_first", 64'(b_rd_data), rec(6, 0, 32'h206));
        // backpressure: head holds
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold", 64'(b_rd_data), rec(6, 0, 32'h206));
        end
        chk("bp_count", 64'(b_count), 64'd64);
        rd_ready = 1'b1;
        for (int i = 0; i < 63; i++) tick();
        rd_ready = 1'b0;
        chk("wrap_last", 64'(b_rd_data), rec(69, 0, 32'h245));
        chk("wrap_last_count", 64'(b_count), 64'd1);
        // re-arm mid-readout
        arm = 1'b1; tick(); arm = 1'b0;
        chk("rearm_state", 64'(b_state), 64'd1);
        chk("rearm_count", 64'(b_count), 64'd0);
        chk("rearm_valid", 64'(b_rd_valid), 64'd0);

        // ---------------- async reset mid-capture ----------------
        wrap = 1'b0; arm = 1'b1; tick(); arm = 1'b0;
        trig = 1'b1; ev_valid = 4'b0011; ev_data[63:0] = {32'h6, 32'h5};
        tick();
        trig = 1'b0; ev_valid = '0;
        tick();
        chk("pre_rst_state", 64'(a_state), 64'd2);
        chk("pre_rst_drop", 64'(a_drop), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 64'(a_state), 64'd0);
        chk("arst_count", 64'(a_count), 64'd0);
        chk("arst_drop", 64'(a_drop), 64'd0);
        chk("arst_valid", 64'(a_rd_valid), 64'd0);
        chk("arst_state_unl", 64'(b_state), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
